usb_wb_bridge: RTL and testbench

- Wishbone-classic slave that fronts the USB core's register bus and EP buffer ports, so the SoC CPU reaches both through one 32-bit window.
- Sits directly upstream of the USB core. It drives bus_addr/bus_din/bus_we/bus_cyc and consumes bus_ack/bus_dout. It also drives the ep_tx_* and ep_rx_* ports.
- The core's ep_clk is tied to clk at the integration level.

---
 rtl/usb_wb_bridge.sv | 170 +++++++++++++++++
 tb/tb_usb_wb_bridge.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_wb_bridge.sv
// Wishbone-classic slave bridging one 32-bit CPU window onto the USB core register bus
// and its endpoint TX/RX buffer ports; every accepted access ends in exactly one wb_ack.
module usb_wb_bridge #(
    parameter int EPDW    = 16,
    parameter int TMO_CYC = 15,
    localparam int EPAW   = 11 - $clog2(EPDW / 8)
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [15:0]     wb_addr,
    input  logic [31:0]     wb_wdata,
    output logic [31:0]     wb_rdata,
    input  logic            wb_we,
    input  logic            wb_cyc,
    input  logic            wb_stb,
    output logic            wb_ack,

    output logic [11:0]     bus_addr,
    output logic [15:0]     bus_din,
    input  logic [15:0]     bus_dout,
    output logic            bus_we,
    output logic            bus_cyc,
    input  logic            bus_ack,

    output logic [EPAW-1:0] ep_tx_addr_0,
    output logic [EPDW-1:0] ep_tx_data_0,
    output logic            ep_tx_we_0,
    output logic [EPAW-1:0] ep_rx_addr_0,
    input  logic [EPDW-1:0] ep_rx_data_1,
    output logic            ep_rx_re_0,

    output logic            tmo_flag
);

    typedef enum logic [2:0] {
        IDLE,
        BUS,
        TXW,
        RXR,
        RXD,
        ACK
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [11:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [31:0] r_rdata;
    logic [7:0]  r_tmo_cnt;
    logic        r_tmo_flag;

    logic        w_req;
    logic [7:0]  w_cnt_nxt;
    logic        w_tmo_hit;
    logic        w_unused;

    assign w_req     = wb_cyc & wb_stb;
    assign w_cnt_nxt = r_tmo_cnt + 8'd1;
    // Abort on the cycle that would make the wait reach TMO_CYC, so bus_cyc is high TMO_CYC cycles.
    assign w_tmo_hit = (w_cnt_nxt == 8'(TMO_CYC));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        bus_cyc     = 1'b0;
        ep_tx_we_0  = 1'b0;
        ep_rx_re_0  = 1'b0;
        wb_ack      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    case (wb_addr[15:14])
                        2'b00:   w_state_nxt = BUS;
                        2'b10:   w_state_nxt = wb_we ? TXW : ACK;
                        2'b11:   w_state_nxt = wb_we ? ACK : RXR;
                        default: w_state_nxt = ACK;
                    endcase
                end
            end
            BUS: begin
                bus_cyc = 1'b1;
                if (bus_ack || w_tmo_hit) begin
                    w_state_nxt = ACK;
                end
            end
            TXW: begin
                ep_tx_we_0  = 1'b1;
                w_state_nxt = ACK;
            end
            RXR: begin
                ep_rx_re_0  = 1'b1;
                w_state_nxt = RXD;
            end
            RXD: begin
                w_state_nxt = ACK;
            end
            ACK: begin
                wb_ack      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request fields are captured only at acceptance and stay frozen until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_rdata    <= '0;
            r_tmo_cnt  <= '0;
            r_tmo_flag <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr    <= wb_addr[11:0];
                        r_wdata   <= wb_wdata;
                        r_we      <= wb_we;
                        r_rdata   <= '0;
                        r_tmo_cnt <= '0;
                    end
                end
                BUS: begin
                    if (bus_ack) begin
                        r_rdata <= {16'h0000, bus_dout};
                    end else begin
                        r_tmo_cnt <= w_cnt_nxt;
                        if (w_tmo_hit) begin
                            r_tmo_flag <= 1'b1;
                        end
                    end
                end
                RXD: begin
                    r_rdata <= 32'(ep_rx_data_1);
                end
                default: begin
                end
            endcase
        end
    end

    assign wb_rdata     = r_rdata;
    assign tmo_flag     = r_tmo_flag;

    assign bus_addr     = r_addr;
    assign bus_din      = r_wdata[15:0];
    assign bus_we       = (r_state == BUS) & r_we;

    assign ep_tx_addr_0 = r_addr[EPAW-1:0];
    assign ep_tx_data_0 = r_wdata[EPDW-1:0];
    assign ep_rx_addr_0 = r_addr[EPAW-1:0];

    // wb_addr[13:12] are don't-care in every space; upper write data only matters for 32-bit EPs.
    assign w_unused = &{1'b0, wb_addr[13:12], r_wdata[31:16]};

endmodule

// File: tb/tb_usb_wb_bridge.sv
// Self-checking bench for usb_wb_bridge: directed scenarios plus a randomized mix,
// with a core register model, an RX buffer model and a reference of the address map.
module tb_usb_wb_bridge;

    localparam int EPDW = 16;
    localparam int EPAW = 10;
    localparam int TMO  = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [15:0]     wb_addr = '0;
    logic [31:0]     wb_wdata = '0;
    logic            wb_we = 1'b0;
    logic            wb_cyc = 1'b0;
    logic            wb_stb = 1'b0;
    logic [31:0]     wb_rdata;
    logic            wb_ack;
    logic [11:0]     bus_addr;
    logic [15:0]     bus_din;
    logic [15:0]     bus_dout = '0;
    logic            bus_we;
    logic            bus_cyc;
    logic            bus_ack = 1'b0;
    logic [EPAW-1:0] ep_tx_addr_0;
    logic [EPDW-1:0] ep_tx_data_0;
    logic            ep_tx_we_0;
    logic [EPAW-1:0] ep_rx_addr_0;
    logic [EPDW-1:0] ep_rx_data_1 = '0;
    logic            ep_rx_re_0;
    logic            tmo_flag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    usb_wb_bridge #(.EPDW(EPDW), .TMO_CYC(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_addr      (wb_addr),
        .wb_wdata     (wb_wdata),
        .wb_rdata     (wb_rdata),
        .wb_we        (wb_we),
        .wb_cyc       (wb_cyc),
        .wb_stb       (wb_stb),
        .wb_ack       (wb_ack),
        .bus_addr     (bus_addr),
        .bus_din      (bus_din),
        .bus_dout     (bus_dout),
        .bus_we       (bus_we),
        .bus_cyc      (bus_cyc),
        .bus_ack      (bus_ack),
        .ep_tx_addr_0 (ep_tx_addr_0),
        .ep_tx_data_0 (ep_tx_data_0),
        .ep_tx_we_0   (ep_tx_we_0),
        .ep_rx_addr_0 (ep_rx_addr_0),
        .ep_rx_data_1 (ep_rx_data_1),
        .ep_rx_re_0   (ep_rx_re_0),
        .tmo_flag     (tmo_flag)
    );

    function automatic logic [15:0] core_init(input logic [11:0] a);
        return 16'h8012 ^ {a, 4'h0};
    endfunction

    function automatic logic [15:0] rx_val(input logic [9:0] a);
        return 16'h1234 ^ {6'd0, a ^ 10'h010};
    endfunction

    // USB core register model: acks core_delay cycles after it first sees bus_cyc.
    int          core_delay = 1;
    bit          core_noack = 1'b0;
    int          core_cnt   = 0;
    logic [15:0] core_mem [4096];
    bit          core_wr  [4096];

    always @(posedge clk) begin
        if (bus_ack) begin
            bus_ack <= 1'b0;
        end else if (bus_cyc && !core_noack) begin
            if (core_cnt + 1 >= core_delay) begin
                bus_ack  <= 1'b1;
                core_cnt <= 0;
                if (bus_we) begin
                    core_mem[bus_addr] <= bus_din;
                    core_wr[bus_addr]  <= 1'b1;
                    bus_dout           <= 16'h0000;
                end else begin
                    bus_dout <= core_wr[bus_addr] ? core_mem[bus_addr] : core_init(bus_addr);
                end
            end else begin
                core_cnt <= core_cnt + 1;
            end
        end else begin
            core_cnt <= 0;
        end
    end

    always @(posedge clk) begin
        if (ep_rx_re_0) ep_rx_data_1 <= rx_val(ep_rx_addr_0);
    end

    // Event monitors, sampled mid-cycle.
    int              cyc_rises = 0, cyc_hi = 0, bus_ack_cnt = 0, dup_err = 0;
    int              wb_ack_cnt = 0, tx_cnt = 0, rx_cnt = 0;
    logic            prev_cyc = 1'b0, prev_ack = 1'b0;
    logic [EPAW-1:0] last_tx_addr = '0, last_rx_addr = '0;
    logic [EPDW-1:0] last_tx_data = '0;
    logic [EPDW-1:0] tx_mem [1024];

    always @(negedge clk) begin
        if (bus_cyc && !prev_cyc) cyc_rises++;
        if (bus_cyc) cyc_hi++;
        if (bus_ack) bus_ack_cnt++;
        if (prev_ack && bus_cyc) dup_err++;
        if (wb_ack) wb_ack_cnt++;
        if (ep_tx_we_0) begin
            tx_cnt++;
            tx_mem[ep_tx_addr_0] = ep_tx_data_0;
            last_tx_addr = ep_tx_addr_0;
            last_tx_data = ep_tx_data_0;
        end
        if (ep_rx_re_0) begin
            rx_cnt++;
            last_rx_addr = ep_rx_addr_0;
        end
        prev_cyc = bus_cyc;
        prev_ack = bus_ack;
    end

    // Reference view of the address map.
    logic [15:0] ref_core [4096];
    bit          ref_core_wr [4096];
    logic [15:0] ref_tx [1024];
    bit          ref_tx_wr [1024];

    function automatic int exp_lat(input logic [15:0] a, input logic we, input int delay);
        case (a[15:14])
            2'b00:   return delay + 2;
            2'b01:   return 1;
            2'b10:   return we ? 2 : 1;
            default: return we ? 1 : 3;
        endcase
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [15:0] a);
        case (a[15:14])
            2'b00:   return {16'h0, ref_core_wr[a[11:0]] ? ref_core[a[11:0]] : core_init(a[11:0])};
            2'b11:   return {16'h0, rx_val(a[9:0])};
            default: return 32'h0;
        endcase
    endfunction

    function automatic void ref_write(input logic [15:0] a, input logic [31:0] d);
        if (a[15:14] == 2'b00) begin
            ref_core[a[11:0]]    = d[15:0];
            ref_core_wr[a[11:0]] = 1'b1;
        end else if (a[15:14] == 2'b10) begin
            ref_tx[a[9:0]]    = d[15:0];
            ref_tx_wr[a[9:0]] = 1'b1;
        end
    endfunction

    // Drives a request at a negedge; returns at the negedge where wb_ack is seen (lat=-1 if never).
    task automatic wb_access(input logic [15:0] a, input logic we, input logic [31:0] d,
                             output logic [31:0] rd, output int lat);
        wb_addr  = a;
        wb_we    = we;
        wb_wdata = d;
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        lat      = -1;
        rd       = 'x;
        @(posedge clk);
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (wb_ack) begin
                lat = n;
                rd  = wb_rdata;
                break;
            end
        end
    endtask

    task automatic wb_idle();
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (wb_ack !== 1'b0)      begin bad++; $display("FAIL reset_wb_ack got=%b exp=0", wb_ack); end
        total++; if (wb_rdata !== 32'h0)   begin bad++; $display("FAIL reset_wb_rdata got=%h exp=0", wb_rdata); end
        total++; if (bus_cyc !== 1'b0)     begin bad++; $display("FAIL reset_bus_cyc got=%b exp=0", bus_cyc); end
        total++; if (bus_we !== 1'b0)      begin bad++; $display("FAIL reset_bus_we got=%b exp=0", bus_we); end
        total++; if (bus_addr !== 12'h0)   begin bad++; $display("FAIL reset_bus_addr got=%h exp=0", bus_addr); end
        total++; if (bus_din !== 16'h0)    begin bad++; $display("FAIL reset_bus_din got=%h exp=0", bus_din); end
        total++; if (ep_tx_we_0 !== 1'b0)  begin bad++; $display("FAIL reset_tx_we got=%b exp=0", ep_tx_we_0); end
        total++; if (ep_rx_re_0 !== 1'b0)  begin bad++; $display("FAIL reset_rx_re got=%b exp=0", ep_rx_re_0); end
        total++; if (tmo_flag !== 1'b0)    begin bad++; $display("FAIL reset_tmo_flag got=%b exp=0", tmo_flag); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reg_read();
        logic [31:0] rd;
        int lat, s_ack, s_hi, s_back;
        core_delay = 1;
        s_ack = wb_ack_cnt; s_hi = cyc_hi; s_back = bus_ack_cnt;
        wb_access(16'h0000, 1'b0, 32'h0, rd, lat);
        wb_idle();
        total++; if (rd !== 32'h0000_8012) begin bad++; $display("FAIL reg_rdata got=%h exp=00008012", rd); end
        total++; if (lat !== exp_lat(16'h0000, 1'b0, 1)) begin bad++; $display("FAIL reg_lat got=%0d exp=%0d", lat, exp_lat(16'h0000, 1'b0, 1)); end
        total++; if (wb_ack_cnt - s_ack !== 1) begin bad++; $display("FAIL reg_ack_count got=%0d exp=1", wb_ack_cnt - s_ack); end
        total++; if (cyc_hi - s_hi !== 2) begin bad++; $display("FAIL reg_cyc_cycles got=%0d exp=2", cyc_hi - s_hi); end
        total++; if (bus_ack_cnt - s_back !== 1) begin bad++; $display("FAIL reg_bus_ack_count got=%0d exp=1", bus_ack_cnt - s_back); end
    endtask

    task automatic test_tx_write();
        logic [31:0] rd;
        int lat, s_tx, s_rise;
        s_tx = tx_cnt; s_rise = cyc_rises;
        wb_access(16'h8005, 1'b1, 32'h5A5A_A5A5, rd, lat);
        wb_idle();
        ref_write(16'h8005, 32'h5A5A_A5A5);
        total++; if (tx_cnt - s_tx !== 1) begin bad++; $display("FAIL tx_pulses got=%0d exp=1", tx_cnt - s_tx); end
        total++; if (last_tx_addr !== 10'h005) begin bad++; $display("FAIL tx_addr got=%h exp=005", last_tx_addr); end
        total++; if (last_tx_data !== 16'hA5A5) begin bad++; $display("FAIL tx_data got=%h exp=a5a5", last_tx_data); end
        total++; if (lat !== 2) begin bad++; $display("FAIL tx_lat got=%0d exp=2", lat); end
        total++; if (cyc_rises - s_rise !== 0) begin bad++; $display("FAIL tx_bus_cyc got=%0d exp=0", cyc_rises - s_rise); end
    endtask

    task automatic test_rx_read();
        logic [31:0] rd;
        int lat, s_rx;
        s_rx = rx_cnt;
        wb_access(16'hC010, 1'b0, 32'h0, rd, lat);
        wb_idle();
        total++; if (rd !== 32'h0000_1234) begin bad++; $display("FAIL rx_rdata got=%h exp=00001234", rd); end
        total++; if (lat !== 3) begin bad++; $display("FAIL rx_lat got=%0d exp=3", lat); end
        total++; if (rx_cnt - s_rx !== 1) begin bad++; $display("FAIL rx_pulses got=%0d exp=1", rx_cnt - s_rx); end
        total++; if (last_rx_addr !== 10'h010) begin bad++; $display("FAIL rx_addr got=%h exp=010", last_rx_addr); end
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        int lat, s_ack, s_hi;
        core_noack = 1'b1;
        s_ack = wb_ack_cnt; s_hi = cyc_hi;
        wb_access(16'h0004, 1'b0, 32'h0, rd, lat);
        wb_idle();
        core_noack = 1'b0;
        total++; if (lat !== TMO + 1) begin bad++; $display("FAIL tmo_lat got=%0d exp=%0d", lat, TMO + 1); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL tmo_rdata got=%h exp=0", rd); end
        total++; if (tmo_flag !== 1'b1) begin bad++; $display("FAIL tmo_flag_set got=%b exp=1", tmo_flag); end
        total++; if (cyc_hi - s_hi !== TMO) begin bad++; $display("FAIL tmo_cyc_cycles got=%0d exp=%0d", cyc_hi - s_hi, TMO); end
        total++; if (wb_ack_cnt - s_ack !== 1) begin bad++; $display("FAIL tmo_ack_count got=%0d exp=1", wb_ack_cnt - s_ack); end
        wb_access(16'h4123, 1'b0, 32'h0, rd, lat);
        wb_idle();
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rsv_rdata got=%h exp=0", rd); end
        total++; if (lat !== 1) begin bad++; $display("FAIL rsv_lat got=%0d exp=1", lat); end
        core_delay = 2;
        wb_access(16'h0003, 1'b0, 32'h0, rd, lat);
        wb_idle();
        total++; if (rd !== exp_rdata(16'h0003)) begin bad++; $display("FAIL post_tmo_rdata got=%h exp=%h", rd, exp_rdata(16'h0003)); end
        total++; if (tmo_flag !== 1'b1) begin bad++; $display("FAIL tmo_flag_sticky got=%b exp=1", tmo_flag); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd1, rd2, exp1;
        int lat1, lat2, s_rise, s_back, s_dup, s_ack, rise_at_ack;
        core_delay = 4;
        exp1 = exp_rdata(16'h0800);
        s_rise = cyc_rises; s_back = bus_ack_cnt; s_dup = dup_err; s_ack = wb_ack_cnt;
        wb_access(16'h0800, 1'b0, 32'h0, rd1, lat1);
        rise_at_ack = cyc_rises - s_rise;
        wb_access(16'h0801, 1'b1, 32'h1357_BEEF, rd2, lat2);
        wb_idle();
        ref_write(16'h0801, 32'h1357_BEEF);
        total++; if (rd1 !== exp1) begin bad++; $display("FAIL b2b_rdata got=%h exp=%h", rd1, exp1); end
        total++; if (lat1 !== exp_lat(16'h0800, 1'b0, 4)) begin bad++; $display("FAIL b2b_lat1 got=%0d exp=%0d", lat1, exp_lat(16'h0800, 1'b0, 4)); end
        total++; if (rise_at_ack !== 1) begin bad++; $display("FAIL b2b_rise_before_ack got=%0d exp=1", rise_at_ack); end
        total++; if (lat2 !== exp_lat(16'h0801, 1'b1, 4) + 1) begin bad++; $display("FAIL b2b_lat2 got=%0d exp=%0d", lat2, exp_lat(16'h0801, 1'b1, 4) + 1); end
        total++; if (cyc_rises - s_rise !== 2) begin bad++; $display("FAIL b2b_rises got=%0d exp=2", cyc_rises - s_rise); end
        total++; if (bus_ack_cnt - s_back !== 2) begin bad++; $display("FAIL b2b_bus_acks got=%0d exp=2", bus_ack_cnt - s_back); end
        total++; if (dup_err - s_dup !== 0) begin bad++; $display("FAIL b2b_cyc_after_ack got=%0d exp=0", dup_err - s_dup); end
        total++; if (wb_ack_cnt - s_ack !== 2) begin bad++; $display("FAIL b2b_wb_acks got=%0d exp=2", wb_ack_cnt - s_ack); end
        core_delay = 1;
        wb_access(16'h0801, 1'b0, 32'h0, rd2, lat2);
        wb_idle();
        total++; if (rd2 !== 32'h0000_BEEF) begin bad++; $display("FAIL b2b_readback got=%h exp=0000beef", rd2); end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd;
        int lat, s_ack;
        core_noack = 1'b1;
        s_ack = wb_ack_cnt;
        wb_addr = 16'h0020; wb_we = 1'b0; wb_wdata = '0; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (bus_cyc !== 1'b1) begin bad++; $display("FAIL midrst_in_bus got=%b exp=1", bus_cyc); end
        repeat (2) @(negedge clk);
        rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        total++; if (bus_cyc !== 1'b0) begin bad++; $display("FAIL midrst_bus_cyc got=%b exp=0", bus_cyc); end
        rst = 1'b0;
        core_noack = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (wb_ack_cnt - s_ack !== 0) begin bad++; $display("FAIL midrst_wb_ack got=%0d exp=0", wb_ack_cnt - s_ack); end
        total++; if (tmo_flag !== 1'b0) begin bad++; $display("FAIL midrst_tmo_clear got=%b exp=0", tmo_flag); end
        core_delay = 2;
        wb_access(16'h0020, 1'b0, 32'h0, rd, lat);
        wb_idle();
        total++; if (rd !== exp_rdata(16'h0020)) begin bad++; $display("FAIL midrst_next_rdata got=%h exp=%h", rd, exp_rdata(16'h0020)); end
        total++; if (lat !== exp_lat(16'h0020, 1'b0, 2)) begin bad++; $display("FAIL midrst_next_lat got=%0d exp=%0d", lat, exp_lat(16'h0020, 1'b0, 2)); end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [31:0] d, rd, er;
        logic [1:0]  sp;
        logic        we;
        int lat, el, dly, s_tx, s_rx, s_ack, s_rise, s_dup;
        s_dup = dup_err;
        for (int i = 0; i < 60; i++) begin
            sp  = 2'($urandom_range(0, 3));
            we  = 1'($urandom_range(0, 1));
            d   = $urandom;
            dly = $urandom_range(1, 5);
            case (sp)
                2'b00:   a = {2'b00, 2'($urandom_range(0, 3)),
                              ($urandom_range(0, 1) != 0 ? 12'h800 : 12'h000) | 12'($urandom_range(0, 7))};
                2'b01:   a = {2'b01, 14'($urandom)};
                default: a = {sp, 4'($urandom), 10'($urandom_range(0, 31))};
            endcase
            core_delay = dly;
            er = exp_rdata(a);
            el = exp_lat(a, we, dly);
            s_tx = tx_cnt; s_rx = rx_cnt; s_ack = wb_ack_cnt; s_rise = cyc_rises;
            wb_access(a, we, d, rd, lat);
            wb_idle();
            if (we) ref_write(a, d);
            total++; if (lat !== el) begin bad++; $display("FAIL rnd_lat addr=%h we=%b got=%0d exp=%0d", a, we, lat, el); end
            if (!we) begin
                total++; if (rd !== er) begin bad++; $display("FAIL rnd_rdata addr=%h got=%h exp=%h", a, rd, er); end
            end
            total++; if (wb_ack_cnt - s_ack !== 1) begin bad++; $display("FAIL rnd_ack_count addr=%h got=%0d exp=1", a, wb_ack_cnt - s_ack); end
            total++; if (tx_cnt - s_tx !== ((sp == 2'b10 && we) ? 1 : 0)) begin bad++; $display("FAIL rnd_tx_pulses addr=%h we=%b got=%0d", a, we, tx_cnt - s_tx); end
            total++; if (rx_cnt - s_rx !== ((sp == 2'b11 && !we) ? 1 : 0)) begin bad++; $display("FAIL rnd_rx_pulses addr=%h we=%b got=%0d", a, we, rx_cnt - s_rx); end
            total++; if (cyc_rises - s_rise !== ((sp == 2'b00) ? 1 : 0)) begin bad++; $display("FAIL rnd_bus_cyc addr=%h got=%0d", a, cyc_rises - s_rise); end
        end
        for (int k = 0; k < 32; k++) begin
            if (ref_tx_wr[k]) begin
                total++; if (tx_mem[k] !== ref_tx[k]) begin bad++; $display("FAIL rnd_tx_mem idx=%0d got=%h exp=%h", k, tx_mem[k], ref_tx[k]); end
            end
        end
        total++; if (dup_err - s_dup !== 0) begin bad++; $display("FAIL rnd_cyc_after_ack got=%0d exp=0", dup_err - s_dup); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reg_read();
        test_tx_write();
        test_rx_read();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
